// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache with miss/write FSM; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl #(
   parameter int LINES = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cpu_rd,
   input  logic             i_cpu_wr,
   input  logic [9:0]       i_cpu_addr,
   input  logic [9:0]       i_cpu_wdata,
   output logic [9:0]       o_cpu_rdata,
   output logic             o_cache_ready,
   input  logic             i_flush,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [9:0]       o_mem_addr,
   output logic [9:0]       o_mem_wdata,
   input  logic [9:0]       i_mem_rdata,
   input  logic             i_mem_ack
`ifdef DCACHE_STATS_EN
   ,
   output logic [CNT_W-1:0] o_hit_count,
   output logic [CNT_W-1:0] o_miss_count
`endif
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 10 - IW;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   logic [1:0]       r_state;
   logic [LINES-1:0] r_valid;
   logic [TW-1:0]    r_tag [LINES];
   logic [9:0]       r_data [LINES];
   logic             r_flush_pend;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [9:0]       r_mem_addr;
   logic [9:0]       r_mem_wdata;
   logic [IW-1:0]    w_idx;
   logic [TW-1:0]    w_tag;
   logic             w_hit;
   logic             w_idle_go;
   logic             w_rd_hit;
   logic             w_fill_go;
   logic             w_wr_go;
   logic             w_fill_ack;
   logic             w_wr_ack;
   assign w_idx         = i_cpu_addr[IW-1:0];
   assign w_tag         = i_cpu_addr[9:IW];
   assign w_hit         = r_valid[w_idx] && r_tag[w_idx] == w_tag;
   // a flush in IDLE wins over any request; the request is retried next cycle
   assign w_idle_go     = r_state == IDLE && !i_flush;
   assign w_rd_hit      = w_idle_go && i_cpu_rd && !i_cpu_wr && w_hit;
   assign w_fill_go     = w_idle_go && i_cpu_rd && !i_cpu_wr && !w_hit;
   assign w_wr_go       = w_idle_go && i_cpu_wr;
   assign w_fill_ack    = r_state == FILL && i_mem_ack;
   assign w_wr_ack      = r_state == WRITE && i_mem_ack;
   assign o_cache_ready = r_state == DONE || (r_state == IDLE && (!(i_cpu_rd || i_cpu_wr) || w_rd_hit));
   assign o_cpu_rdata   = (o_cache_ready && i_cpu_rd && !i_cpu_wr) ? r_data[w_idx] : 10'd0;
   assign o_mem_req     = r_mem_req;
   assign o_mem_we      = r_mem_we;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_wdata   = r_mem_wdata;
   // control FSM, valid bits and the registered memory request
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_flush_pend <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 10'd0;
         r_mem_wdata  <= 10'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_flush) r_valid <= '0;
               if (w_wr_go || w_fill_go) begin
                  r_state     <= w_wr_go ? WRITE : FILL;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_wr_go;
                  r_mem_addr  <= i_cpu_addr;
                  r_mem_wdata <= w_wr_go ? i_cpu_wdata : r_mem_wdata;
               end
            end
            FILL, WRITE: begin
               if (i_flush) r_flush_pend <= 1'b1;
               if (w_fill_ack) r_valid[w_idx] <= 1'b1;
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= DONE;
               end
            end
            default: begin
               if (i_flush || r_flush_pend) r_valid <= '0;
               r_flush_pend <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end
   // line storage: fills load tag and data, write hits update data only
   always_ff @(posedge i_clk) begin
      if (w_fill_ack) begin
         r_data[w_idx] <= i_mem_rdata;
         r_tag[w_idx]  <= w_tag;
      end else if (w_wr_ack && w_hit) begin
         r_data[w_idx] <= i_cpu_wdata;
      end
   end
`ifdef DCACHE_STATS_EN
   logic [CNT_W-1:0] r_hit_count;
   logic [CNT_W-1:0] r_miss_count;
   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;
   // saturating counters of read hits and fill entries
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_rd_hit && r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
         if (w_fill_go && r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl; stats checks built when DCACHE_STATS_EN is defined
module tb_dcache_ctrl;
   typedef struct packed {
      logic       we;
      logic [9:0] addr;
      logic [9:0] wdata;
   } mreq_t;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_rd = 1'b0;
   logic       cpu_wr = 1'b0;
   logic [9:0] cpu_addr = 10'd0;
   logic [9:0] cpu_wdata = 10'd0;
   logic       flush = 1'b0;
   logic [9:0] mem_rdata = 10'd0;
   logic       mem_ack = 1'b0;
   logic [9:0] cpu_rdata;
   logic       cache_ready;
   logic       mem_req;
   logic       mem_we;
   logic [9:0] mem_addr;
   logic [9:0] mem_wdata;
`ifdef DCACHE_STATS_EN
   logic [3:0] hit_count;
   logic [3:0] miss_count;
`endif
   int         n_tests = 0;
   int         n_fail = 0;
   int         ack_dly = 0;
   logic [9:0] mem [1024];
   mreq_t      mq[$];
   logic [9:0] rq[$];

   dcache_ctrl #(.LINES(8), .CNT_W(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
      .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
      .o_cache_ready(cache_ready), .i_flush(flush), .o_mem_req(mem_req),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
      , .o_hit_count(hit_count), .o_miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // memory model: ack ack_dly cycles after mem_req rises, one-cycle strobe
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mem_req) cnt = 0;
         else if (cnt == ack_dly) begin
            mem_ack = 1'b1;
            cnt++;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem[mem_addr];
         end else if (cnt < ack_dly) cnt++;
      end
   end

   // monitor: compares memory requests and completed loads against the queues
   initial begin
      logic  prev_req;
      mreq_t m;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && !prev_req) begin
            if (mq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL mreq_unexpected: got addr %0h expected none", mem_addr);
            end else begin
               m = mq.pop_front();
               check("mem_we", mem_we, m.we);
               check("mem_addr", mem_addr, m.addr);
               if (m.we) check("mem_wdata", mem_wdata, m.wdata);
            end
         end
         prev_req = mem_req;
         if (cache_ready && cpu_rd && !cpu_wr) begin
            if (rq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rdata_unexpected: got %0h expected none", cpu_rdata);
            end else check("cpu_rdata", cpu_rdata, rq.pop_front());
         end
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [9:0] a, input logic [9:0] wd,
                         input int dly, input int exp_st, input logic [9:0] exp_rd, input string name);
      int    st;
      mreq_t m;
      st = 0;
      ack_dly = dly;
      if (rd && !wr) rq.push_back(exp_rd);
      if (wr || exp_st > 0) begin
         m.we = wr;
         m.addr = a;
         m.wdata = wr ? wd : 10'd0;
         mq.push_back(m);
      end
      @(posedge clk);
      #1;
      cpu_rd = rd;
      cpu_wr = wr;
      cpu_addr = a;
      cpu_wdata = wd;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (cache_ready) break;
         st++;
      end
      check({name, "_stalls"}, st, exp_st);
      @(posedge clk);
      #1;
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mreq_t m;
      mem[10'h013] = 10'h2A5;
      mem[10'h01B] = 10'h0C3;
      mem[10'h040] = 10'h111;
      @(negedge clk);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 10'd0);
      check("rst_mem_wdata", mem_wdata, 10'd0);
      check("rst_cpu_rdata", cpu_rdata, 10'd0);
      check("rst_ready", cache_ready, 1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      // reset in the middle of a fill
      ack_dly = 20;
      m.we = 1'b0;
      m.addr = 10'h013;
      m.wdata = 10'd0;
      mq.push_back(m);
      @(posedge clk);
      #1;
      cpu_rd = 1'b1;
      cpu_addr = 10'h013;
      repeat (4) @(posedge clk);
      check("fill_req_up", mem_req, 1'b1);
      #3;
      cpu_rd = 1'b0;
      reset = 1'b0;
      #1;
      check("async_rst_req", mem_req, 1'b0);
      check("async_rst_ready", cache_ready, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      access(1, 0, 10'h013, 0, 3, 5, 10'h2A5, "miss_after_rst");
      access(1, 0, 10'h013, 0, 0, 0, 10'h2A5, "hit_013");
      access(1, 0, 10'h01B, 0, 1, 3, 10'h0C3, "conflict_01B");
      access(1, 0, 10'h013, 0, 0, 2, 10'h2A5, "remiss_013");
      access(0, 1, 10'h013, 10'h155, 2, 4, 0, "wr_hit");
      access(1, 0, 10'h013, 0, 0, 0, 10'h155, "hit_after_wr");
      access(0, 1, 10'h040, 10'h0AA, 1, 3, 0, "wr_miss");
      access(1, 0, 10'h040, 0, 1, 3, 10'h0AA, "rd_after_wr_miss");
      fork
         access(1, 0, 10'h01B, 0, 4, 6, 10'h0C3, "flush_in_fill");
         begin
            repeat (3) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
         end
      join
      access(1, 0, 10'h01B, 0, 0, 2, 10'h0C3, "miss_after_flush");
      access(1, 0, 10'h013, 0, 0, 2, 10'h155, "refill_013");
      fork
         access(1, 0, 10'h013, 0, 0, 3, 10'h155, "flush_in_idle");
         begin
            @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
         end
      join
`ifdef DCACHE_STATS_EN
      @(posedge clk);
      #3 reset = 1'b0;
      #4 reset = 1'b1;
      check("stats_rst_hit", hit_count, 4'h0);
      check("stats_rst_miss", miss_count, 4'h0);
      access(1, 0, 10'h013, 0, 0, 2, 10'h155, "stats_miss1");
      check("miss_count_1", miss_count, 4'h1);
      access(1, 0, 10'h01B, 0, 0, 2, 10'h0C3, "stats_miss2");
      check("miss_count_2", miss_count, 4'h2);
      check("hit_count_0", hit_count, 4'h0);
      for (int i = 0; i < 20; i++) access(1, 0, 10'h01B, 0, 0, 0, 10'h0C3, "stats_hit");
      check("hit_count_sat", hit_count, 4'hF);
      check("miss_count_end", miss_count, 4'h2);
`endif
      repeat (2) @(posedge clk);
      check("rq_drained", rq.size(), 0);
      check("mq_drained", mq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
